sc_reg_player: RTL and testbench

SC_REG_PLAYER -- requirements
Module: sc_reg_player

---
 rtl/sc_reg_player_pkg.sv | 27 ++
 rtl/sc_repeat_timer.sv | 30 +++
 rtl/sc_reg_player.sv | 143 ++++++++++++++
 tb/tb_sc_reg_player.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_reg_player_pkg.sv
// Shared types for the register-based player: FSM states and move-direction encoding.
package sc_reg_player_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD_L = 2'b01,
        HOLD_R = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10
    } dir_t;

    // A direction counts only when exactly one of the two requests is high.
    function automatic dir_t decodeDir(input logic left, input logic right);
        if (left && !right) begin
            return LEFT;
        end
        if (right && !left) begin
            return RIGHT;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/sc_repeat_timer.sv
// Hold-to-repeat counter: counts enabled cycles and flags the terminal count.
module sc_repeat_timer #(
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // High while the counter sits at its last value; the owner qualifies it with enable.
    assign tick_c = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || (enable && tick_c)) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sc_reg_player.sv
// Player position register: clear/load/move with hold-to-repeat and optional wrap at the edges.
module sc_reg_player
    import sc_reg_player_pkg::*;
#(
    parameter int unsigned             DATAWIDTH     = 8,
    parameter logic [DATAWIDTH-1:0]    INIT_POS      = DATAWIDTH'(8'b0001_0000),
    parameter bit                      WRAP          = 1'b1,
    parameter int unsigned             REPEAT_CYCLES = 12500000
) (
    input  logic                 SC_RegPLAYER_CLOCK_50,
    input  logic                 SC_RegPLAYER_RESET_InLow,
    input  logic                 SC_RegPLAYER_clear_InLow,
    input  logic                 SC_RegPLAYER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_RegPLAYER_data_InBUS,
    input  logic                 SC_RegPLAYER_left_InHigh,
    input  logic                 SC_RegPLAYER_right_InHigh,
    output logic [DATAWIDTH-1:0] SC_RegPLAYER_data_OutBUS,
    output logic                 SC_RegPLAYER_leftEdge_Out,
    output logic                 SC_RegPLAYER_rightEdge_Out,
    output logic                 SC_RegPLAYER_moved_Out
);

    logic [1:0]           rstPipe;
    logic                 rstN;
    state_t               state;
    state_t               stateNext;
    logic [DATAWIDTH-1:0] pos;
    logic [DATAWIDTH-1:0] posNext;
    logic                 moved;
    logic                 movedNext;
    dir_t                 dir;
    dir_t                 moveDir;
    logic                 timerClear;
    logic                 timerEnable;
    logic                 timerTick;
    logic [DATAWIDTH-1:0] leftShift;
    logic [DATAWIDTH-1:0] rightShift;
    logic                 leftBlocked;
    logic                 rightBlocked;

    // Reset asserts immediately but releases two clock edges later, aligned to the clock.
    always_ff @(posedge SC_RegPLAYER_CLOCK_50 or negedge SC_RegPLAYER_RESET_InLow) begin
        if (!SC_RegPLAYER_RESET_InLow) begin
            rstPipe <= 2'b00;
        end else begin
            rstPipe <= {rstPipe[0], 1'b1};
        end
    end

    assign rstN = rstPipe[1];

    sc_repeat_timer #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_timer (
        .clk   (SC_RegPLAYER_CLOCK_50),
        .rst_n (rstN),
        .clear (timerClear),
        .enable(timerEnable),
        .tick_c(timerTick)
    );

    assign dir = decodeDir(SC_RegPLAYER_left_InHigh, SC_RegPLAYER_right_InHigh);

    // Candidate shifted positions; without wrap a move off the edge is blocked.
    assign leftShift    = WRAP ? {pos[DATAWIDTH-2:0], pos[DATAWIDTH-1]} : {pos[DATAWIDTH-2:0], 1'b0};
    assign rightShift   = WRAP ? {pos[0], pos[DATAWIDTH-1:1]} : {1'b0, pos[DATAWIDTH-1:1]};
    assign leftBlocked  = !WRAP && pos[DATAWIDTH-1];
    assign rightBlocked = !WRAP && pos[0];

    always_comb begin
        stateNext   = state;
        posNext     = pos;
        movedNext   = 1'b0;
        moveDir     = NONE;
        timerClear  = 1'b0;
        timerEnable = 1'b0;

        if (!SC_RegPLAYER_clear_InLow) begin
            posNext    = INIT_POS;
            stateNext  = IDLE;
            timerClear = 1'b1;
        end else if (!SC_RegPLAYER_load_InLow) begin
            posNext    = SC_RegPLAYER_data_InBUS;
            stateNext  = IDLE;
            timerClear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (dir != NONE) begin
                        moveDir    = dir;
                        stateNext  = (dir == LEFT) ? HOLD_L : HOLD_R;
                        timerClear = 1'b1;
                    end
                end
                HOLD_L, HOLD_R: begin
                    if (dir == NONE) begin
                        stateNext  = IDLE;
                        timerClear = 1'b1;
                    end else if ((dir == LEFT) == (state == HOLD_L)) begin
                        timerEnable = 1'b1;
                        if (timerTick) begin
                            moveDir = dir;
                        end
                    end else begin
                        moveDir    = dir;
                        stateNext  = (dir == LEFT) ? HOLD_L : HOLD_R;
                        timerClear = 1'b1;
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    timerClear = 1'b1;
                end
            endcase

            if (moveDir == LEFT && !leftBlocked) begin
                posNext = leftShift;
            end else if (moveDir == RIGHT && !rightBlocked) begin
                posNext = rightShift;
            end
            // Pulse only on a real change, so all-zero or blocked moves stay silent.
            movedNext = (moveDir != NONE) && (posNext != pos);
        end
    end

    always_ff @(posedge SC_RegPLAYER_CLOCK_50 or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            pos   <= INIT_POS;
            moved <= 1'b0;
        end else begin
            state <= stateNext;
            pos   <= posNext;
            moved <= movedNext;
        end
    end

    assign SC_RegPLAYER_data_OutBUS   = pos;
    assign SC_RegPLAYER_moved_Out     = moved;
    assign SC_RegPLAYER_leftEdge_Out  = pos[DATAWIDTH-1];
    assign SC_RegPLAYER_rightEdge_Out = pos[0];

endmodule

// File: tb/tb_sc_reg_player.sv
// Bench for sc_reg_player: wrap and saturate instances driven together against a press-age model.
module tb_sc_reg_player;

    localparam int R = 4;
    localparam logic [7:0] INIT = 8'h10;

    logic       clk = 1'b0;
    logic       rstN;
    logic       clrN;
    logic       ldN;
    logic       left;
    logic       right;
    logic [7:0] data;

    logic [7:0] posA, posB;
    logic       lEA, rEA, movA;
    logic       lEB, rEB, movB;

    int checks = 0;
    int errors = 0;

    // Model: position per instance, which direction is held and how many cycles it has been held.
    int         heldDir = 0;
    int         age = 0;
    logic [7:0] mPosA = INIT;
    logic [7:0] mPosB = INIT;
    logic       mMovA = 1'b0;
    logic       mMovB = 1'b0;

    always #5 clk = ~clk;

    sc_reg_player #(.DATAWIDTH(8), .WRAP(1'b1), .REPEAT_CYCLES(R)) dutWrap (
        .SC_RegPLAYER_CLOCK_50     (clk),
        .SC_RegPLAYER_RESET_InLow  (rstN),
        .SC_RegPLAYER_clear_InLow  (clrN),
        .SC_RegPLAYER_load_InLow   (ldN),
        .SC_RegPLAYER_data_InBUS   (data),
        .SC_RegPLAYER_left_InHigh  (left),
        .SC_RegPLAYER_right_InHigh (right),
        .SC_RegPLAYER_data_OutBUS  (posA),
        .SC_RegPLAYER_leftEdge_Out (lEA),
        .SC_RegPLAYER_rightEdge_Out(rEA),
        .SC_RegPLAYER_moved_Out    (movA)
    );

    sc_reg_player #(.DATAWIDTH(8), .WRAP(1'b0), .REPEAT_CYCLES(R)) dutSat (
        .SC_RegPLAYER_CLOCK_50     (clk),
        .SC_RegPLAYER_RESET_InLow  (rstN),
        .SC_RegPLAYER_clear_InLow  (clrN),
        .SC_RegPLAYER_load_InLow   (ldN),
        .SC_RegPLAYER_data_InBUS   (data),
        .SC_RegPLAYER_left_InHigh  (left),
        .SC_RegPLAYER_right_InHigh (right),
        .SC_RegPLAYER_data_OutBUS  (posB),
        .SC_RegPLAYER_leftEdge_Out (lEB),
        .SC_RegPLAYER_rightEdge_Out(rEB),
        .SC_RegPLAYER_moved_Out    (movB)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move arithmetic: d=1 toward MSB, d=2 toward LSB.
    function automatic logic [7:0] moveOf(input logic [7:0] p, input int d, input bit wrap);
        int v;
        v = int'(p);
        if (d == 1) begin
            if (wrap) return 8'(((v * 2) % 256) + (v / 128));
            return (v >= 128) ? p : 8'((v * 2) % 256);
        end
        if (wrap) return 8'((v / 2) + ((v % 2) * 128));
        return ((v % 2) == 1) ? p : 8'(v / 2);
    endfunction

    task automatic modelReset();
        mPosA   = INIT;
        mPosB   = INIT;
        mMovA   = 1'b0;
        mMovB   = 1'b0;
        heldDir = 0;
        age     = 0;
    endtask

    task automatic modelStep(input logic l, input logic r, input logic c, input logic ld, input logic [7:0] d);
        int         dirNow;
        logic [7:0] np;
        mMovA = 1'b0;
        mMovB = 1'b0;
        if (!c) begin
            mPosA = INIT; mPosB = INIT; heldDir = 0;
        end else if (!ld) begin
            mPosA = d; mPosB = d; heldDir = 0;
        end else begin
            dirNow = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
            if (dirNow == 0) begin
                heldDir = 0;
            end else begin
                if (dirNow != heldDir) begin
                    heldDir = dirNow;
                    age = 0;
                end else begin
                    age++;
                end
                // A fresh press moves at once, then every R cycles of continued holding.
                if ((age % R) == 0) begin
                    np = moveOf(mPosA, dirNow, 1'b1);
                    mMovA = (np != mPosA);
                    mPosA = np;
                    np = moveOf(mPosB, dirNow, 1'b0);
                    mMovB = (np != mPosB);
                    mPosB = np;
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".posW"},  posA, mPosA);
        check({tag, ".lEdgeW"}, 8'(lEA), 8'(mPosA[7]));
        check({tag, ".rEdgeW"}, 8'(rEA), 8'(mPosA[0]));
        check({tag, ".movW"},  8'(movA), 8'(mMovA));
        check({tag, ".posS"},  posB, mPosB);
        check({tag, ".lEdgeS"}, 8'(lEB), 8'(mPosB[7]));
        check({tag, ".rEdgeS"}, 8'(rEB), 8'(mPosB[0]));
        check({tag, ".movS"},  8'(movB), 8'(mMovB));
    endtask

    task automatic step(input logic l, input logic r, input logic c, input logic ld,
                        input logic [7:0] d, input string tag);
        left = l; right = r; clrN = c; ldN = ld; data = d;
        modelStep(l, r, c, ld, d);
        @(negedge clk);
        checkAll(tag);
    endtask

    initial begin
        int         moves;
        int         hold;
        logic       rl, rr, rc, rld;
        logic [7:0] rd;

        rstN = 1'b0; clrN = 1'b1; ldN = 1'b1; left = 1'b0; right = 1'b0; data = 8'h00;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll("in_reset");
        rstN = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "after_reset");
        check("reset_pos_const", posA, 8'h10);

        // Held left: moves at cycles 0, 4 and 8.
        moves = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "hold_left");
            if (movA) moves++;
        end
        check("hold_left_pos", posA, 8'h80);
        check("hold_left_pulses", 8'(moves), 8'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "release");

        // Left press at the MSB: wraps on one instance, blocked on the other.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h80, "load80");
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "edge_left");
        check("edge_wrap_pos", posA, 8'h01);
        check("edge_wrap_redge", 8'(rEA), 8'd1);
        check("edge_sat_pos", posB, 8'h80);
        check("edge_sat_moved", 8'(movB), 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "release");

        // Both directions together are no request; a following left is a fresh press.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, "load10");
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "both");
        check("both_pos", posA, 8'h10);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "after_both");
        check("after_both_pos", posA, 8'h20);

        // Clear mid-hold, then the still-held direction acts as a fresh press.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "clear");
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "pre_clear_hold");
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "clear_mid_hold");
        check("clear_mid_pos", posA, 8'h10);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "post_clear");
        check("post_clear_pos", posA, 8'h20);

        // Loaded zero never moves and never pulses.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "load0");
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "zero_right");

        // Asynchronous reset between edges during a right hold.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, "load10b");
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "hold_right");
        #2;
        rstN = 1'b0; right = 1'b0;
        modelReset();
        #1;
        check("async_rst_posW", posA, 8'h10);
        check("async_rst_posS", posB, 8'h10);
        check("async_rst_movW", 8'(movA), 8'd0);
        #1;
        rstN = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "after_async_rst");

        // Randomized run with sticky inputs so holds last long enough to repeat.
        rl = 1'b0; rr = 1'b0;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                rl = 1'($urandom_range(1, 0));
                rr = 1'($urandom_range(1, 0));
                hold = int'($urandom_range(12, 1));
            end
            hold--;
            rc  = ($urandom_range(39, 0) != 0);
            rld = ($urandom_range(19, 0) != 0);
            rd  = ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'(1 << $urandom_range(7, 0));
            step(rl, rr, rc, rld, rd, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
